// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the serial sequence detectors: valid/ready word input,
// one bit per clock on o, a one-word holding buffer for bubble-free streaming, and an optional idle gap.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             o,
  output logic             o_valid,
  output logic             o_last,
  output logic             busy
);

  localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   sr, sr_d;
  logic [WIDTH-1:0]   hb, hb_d;
  logic               hold_full, hold_full_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic               o_d, o_valid_d, o_last_d, din_ready_d, busy_d;
  logic               accept, last_bit, reload, din_to_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sr        <= '0;
      hb        <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      gap_cnt   <= '0;
      o         <= 1'b0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      din_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      hb        <= hb_d;
      hold_full <= hold_full_d;
      cnt       <= cnt_d;
      gap_cnt   <= gap_cnt_d;
      o         <= o_d;
      o_valid   <= o_valid_d;
      o_last    <= o_last_d;
      din_ready <= din_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state;
    sr_d        = sr;
    hb_d        = hb;
    hold_full_d = hold_full;
    cnt_d       = cnt;
    gap_cnt_d   = gap_cnt;
    o_d         = 1'b0;
    o_valid_d   = 1'b0;
    o_last_d    = 1'b0;
    din_to_sr   = 1'b0;

    accept   = din_valid && din_ready;
    last_bit = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    // Final gap cycle acts as IDLE so the gap is exactly GAP cycles long.
    reload   = (state == ST_IDLE)
            || ((state == ST_GAP) && (gap_cnt == GAP_W'(GAP_LAST)))
            || (last_bit && (GAP == 0));

    case (state)
      ST_SHIFT: begin
        o_valid_d = 1'b1;
        o_d       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        sr_d      = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        cnt_d     = cnt + CNT_W'(1);
        if (last_bit) begin
          o_last_d  = 1'b1;
          cnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Held word has priority over a fresh one so ordering is preserved.
    if (reload) begin
      if (hold_full) begin
        sr_d        = hb;
        hold_full_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_SHIFT;
      end else if (accept) begin
        sr_d      = din;
        din_to_sr = 1'b1;
        cnt_d     = '0;
        state_d   = ST_SHIFT;
      end
    end

    if (accept && !din_to_sr) begin
      hb_d        = din;
      hold_full_d = 1'b1;
    end

    din_ready_d = !hold_full_d;
    busy_d      = (state_d != ST_IDLE) || hold_full_d;
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomized bench for seq_bit_serializer: three parameter sets, each checked every cycle
// against a word-timing reference model (start = max(accept+1, prev_end+1+GAP)).
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CW = (g == 2) ? 4 : 8;
    localparam bit CM = (g == 1) ? 1'b0 : 1'b1;
    localparam int CG = (g == 1) ? 2 : 0;

    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [CW-1:0] din = '0;
    logic          din_ready, o, o_valid, o_last, busy;

    seq_bit_serializer #(.WIDTH(CW), .MSB_FIRST(CM), .GAP(CG)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .o         (o),
      .o_valid   (o_valid),
      .o_last    (o_last),
      .busy      (busy)
    );

    int            cyc      = 0;
    int            last_end = -1000;
    logic [CW-1:0] q_word[$];
    int            q_acc[$];
    int            q_start[$];

    function automatic string tg(input string s);
      return $sformatf("cfg%0d.%s", g, s);
    endfunction

    // A word sits in the holding buffer from acceptance until the edge before its first bit.
    function automatic bit m_hold(input int c);
      foreach (q_acc[i]) begin
        if (q_acc[i] <= c && c < q_start[i] - 1) return 1'b1;
      end
      return 1'b0;
    endfunction

    function automatic void m_out(input int c, output bit v, output bit b, output bit l);
      logic [CW-1:0] w;
      int k;
      v = 1'b0; b = 1'b0; l = 1'b0;
      foreach (q_start[i]) begin
        if (c >= q_start[i] && c <= q_start[i] + CW - 1) begin
          k = c - q_start[i];
          w = q_word[i];
          v = 1'b1;
          b = w[CM ? (CW - 1 - k) : k];
          l = (k == CW - 1);
        end
      end
    endfunction

    task automatic tick(output bit acc);
      bit v, b, l;
      int st;
      acc = din_valid && !rst && !m_hold(cyc);
      @(posedge clk);
      cyc++;
      if (rst) begin
        q_word.delete(); q_acc.delete(); q_start.delete();
        last_end = -1000;
      end else if (acc) begin
        st = (cyc + 1 > last_end + 1 + CG) ? cyc + 1 : last_end + 1 + CG;
        last_end = st + CW - 1;
        q_word.push_back(din); q_acc.push_back(cyc); q_start.push_back(st);
      end
      while (q_start.size() > 0 && q_start[0] + CW - 1 < cyc) begin
        void'(q_word.pop_front()); void'(q_acc.pop_front()); void'(q_start.pop_front());
      end
      @(negedge clk);
      m_out(cyc, v, b, l);
      check(tg("o_valid"),   32'(o_valid),   32'(v));
      check(tg("o"),         32'(o),         32'(b));
      check(tg("o_last"),    32'(o_last),    32'(l));
      check(tg("busy"),      32'(busy),      32'(last_end + CG > cyc));
      check(tg("din_ready"), 32'(din_ready), 32'(!m_hold(cyc)));
    endtask

    // Holds din stable with din_valid high until the word is taken.
    task automatic present(input logic [CW-1:0] w);
      bit acc;
      int n;
      n = 0;
      din = w;
      din_valid = 1'b1;
      do begin
        tick(acc);
        n++;
      end while (!acc && n < 100);
      if (!acc) check(tg("accept_timeout"), 32'(acc), 32'd1);
    endtask

    initial begin : stim
      bit acc;
      int rem;
      int dens;
      acc = 1'b0;
      rem = 0;
      dens = 50;
      tick(acc); tick(acc);
      rst = 1'b0;
      tick(acc);

      // Reset in the middle of a word drops it completely.
      present(CW'(32'hA5));
      din_valid = 1'b0;
      repeat (3) tick(acc);
      rst = 1'b1;
      tick(acc); tick(acc);
      rst = 1'b0;
      repeat (12) tick(acc);

      if (g == 0) begin
        present(CW'(32'hCC));
        din_valid = 1'b0;
        repeat (12) tick(acc);
        present(CW'(32'h0C));
        present(CW'(32'hC0));
        din_valid = 1'b0;
        repeat (20) tick(acc);
        present(CW'(32'h11));
        present(CW'(32'h22));
        present(CW'(32'h33));
        din_valid = 1'b0;
        repeat (30) tick(acc);
      end else if (g == 1) begin
        present(CW'(32'h03));
        present(CW'(32'h05));
        din_valid = 1'b0;
        repeat (30) tick(acc);
      end else begin
        present(CW'(32'hC));
        din_valid = 1'b0;
        repeat (3) begin
          while (cyc < last_end - 1) tick(acc);
          present(CW'(32'hC));
          din_valid = 1'b0;
        end
        repeat (12) tick(acc);
      end

      acc = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if (i % 100 == 0) dens = (i % 300 == 0) ? 100 : ((i % 200 == 0) ? 30 : 85);
        if (rem > 0) begin
          rst = 1'b1;
          rem--;
        end else begin
          rst = 1'b0;
          if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            rem = $urandom_range(0, 1);
          end
        end
        if (!din_valid || acc) begin
          din_valid = ($urandom_range(0, 99) < dens);
          din = CW'($urandom());
        end
        tick(acc);
      end

      rst = 1'b0;
      din_valid = 1'b0;
      repeat (40) tick(acc);
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && n_done < 3; i++) @(posedge clk);
    check("all_configs_done", 32'(n_done), 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
